// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The controller drives the master side; the unit implements the slave side.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, srca, srcb, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, srca, srcb, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: one bit per cycle, shift-add multiply
// and restoring divide on operand magnitudes, with a 1-cycle divide fast path.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);
  localparam int              CW   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic            r_neg, r_fast;
  logic [XLEN-1:0] r_fast_res, r_m, r_hi, r_lo, r_result;
  logic [CW-1:0]   r_cnt;

  logic            w_accept, w_in_ready, w_out_valid, w_last;
  logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg, w_div0, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_fast_res, w_hi_nxt, w_lo_nxt;
  logic [XLEN:0]   w_mul_sum, w_trial, w_diff;

  function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // p holds {hi, lo}: the full product for multiplies, {remainder, quotient} for divides.
  function automatic logic [XLEN-1:0] f_finish(input logic [2:0] op, input logic neg,
                                               input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] sp;
    logic [XLEN-1:0]   hi, lo;
    sp = neg ? (~p + 1'b1) : p;
    hi = p[2*XLEN-1:XLEN];
    lo = p[XLEN-1:0];
    case (op)
      3'b000:                 f_finish = sp[XLEN-1:0];
      3'b001, 3'b010, 3'b011: f_finish = sp[2*XLEN-1:XLEN];
      3'b100, 3'b101:         f_finish = neg ? (~lo + 1'b1) : lo;
      default:                f_finish = neg ? (~hi + 1'b1) : hi;
    endcase
  endfunction

  // Operand decode, evaluated on the accept edge only.
  always_comb begin
    w_a_sgn    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    w_b_sgn    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110);
    w_a_neg    = w_a_sgn & bus.srca[XLEN-1];
    w_b_neg    = w_b_sgn & bus.srcb[XLEN-1];
    w_neg      = (bus.funct3[2] & bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_a_mag    = f_mag(bus.srca, w_a_neg);
    w_b_mag    = f_mag(bus.srcb, w_b_neg);
    w_div0     = bus.funct3[2] & (bus.srcb == '0);
    w_ovf      = bus.funct3[2] & ~bus.funct3[0] & (bus.srca == SMIN) & (bus.srcb == '1);
    if (w_div0) w_fast_res = bus.funct3[1] ? bus.srca : '1;
    else        w_fast_res = bus.funct3[1] ? '0 : bus.srca;
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    w_trial   = {r_hi, r_lo[XLEN-1]};
    w_diff    = w_trial - {1'b0, r_m};
    if (r_op[2]) begin
      w_hi_nxt = w_diff[XLEN] ? w_trial[XLEN-1:0] : w_diff[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_last      = (r_cnt == CW'(XLEN - 1));
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        if (r_fast || w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_accept = w_in_ready & bus.in_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_res <= '0;
      r_m        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_op       <= bus.funct3;
      r_neg      <= w_neg;
      r_fast     <= w_div0 | w_ovf;
      r_fast_res <= w_fast_res;
      r_m        <= bus.funct3[2] ? w_b_mag : w_a_mag;
      r_lo       <= bus.funct3[2] ? w_a_mag : w_b_mag;
      r_hi       <= '0;
      r_cnt      <= '0;
    end else if (r_state == CALC) begin
      if (r_fast) begin
        r_result <= r_fast_res;
      end else begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_result <= f_finish(r_op, r_neg, {w_hi_nxt, w_lo_nxt});
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, handshake/reset sequences,
// and random operations checked against a plain-arithmetic reference.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[16];
  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] sp[5];
    sp = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Called #1 after a clock edge; returns #1 after the edge where out_valid was seen.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit noisy, output logic [31:0] res, output int lat);
    int guard;
    bus.funct3   = op;
    bus.srca     = a;
    bus.srcb     = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (noisy) begin
        bus.in_valid  = 1'b1;
        bus.srca      = $urandom;
        bus.srcb      = $urandom;
        bus.funct3    = 3'($urandom);
        bus.out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    res = bus.result;
  endtask

  task automatic finish_out(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check32({name, ".idle_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    check32({name, ".idle_vld"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic run_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit noisy);
    logic [31:0] res;
    int          got_lat;
    do_op(op, a, b, noisy, res, got_lat);
    check32({name, ".res"}, res, exp);
    check32({name, ".lat"}, 32'(got_lat), 32'(lat));
    finish_out(name);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          lat_unused;

    tbl[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32};
    tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
    tbl[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32};
    tbl[6]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32};
    tbl[7]  = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32};
    tbl[8]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    tbl[12] = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    tbl[13] = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    tbl[14] = '{3'd0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32};
    tbl[15] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.funct3    = 3'd0;
    bus.srca      = '0;
    bus.srcb      = '0;
    reset_n       = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check32("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check32("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("rst.result", bus.result, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      run_vec($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 1'b0);

    // Backpressure: result held while out_ready stays low, new requests ignored.
    do_op(3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, held, lat_unused);
    check32("bp.res", held, 32'h7FFF_FFFC);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.funct3   = 3'd0;
      bus.srca     = $urandom;
      bus.srcb     = $urandom;
      @(posedge clk); #1;
      check32($sformatf("bp.hold%0d", k), bus.result, 32'h7FFF_FFFC);
      check32($sformatf("bp.busy%0d", k), {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0;
    finish_out("bp");
    run_vec("b2b0", 3'd7, 32'd100, 32'd7, 32'd2, 32, 1'b0);
    run_vec("b2b1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 1'b0);

    // Reset in the middle of a multiply.
    bus.funct3   = 3'd0;
    bus.srca     = 32'hFFFF_FFFF;
    bus.srcb     = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check32("mid_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check32("mid_rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("mid_rst.result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    run_vec("post_rst", 3'd0, 32'd3, 32'd4, 32'd12, 32, 1'b0);

    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom);
      ra  = pick();
      rb  = pick();
      run_vec($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), rop, ra, rb,
              ref_model(rop, ra, rb), ref_lat(rop, ra, rb), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised RV32M/RV64M multiply/divide execution unit, the next step beyond the combinational ALU decode path.
- Decodes funct3 for the M-extension operations and computes them iteratively, one bit per cycle, using a shift-add multiplier and a restoring divider.
- Sits beside the main ALU. The controller issues work through a valid/ready handshake and stalls on in_ready/out_valid.
- Special divide cases complete on a 1-cycle fast path.

Parameters:
- XLEN, 32, operand/result width; must be >= 4 and even.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept an operation.
- funct3  input  3  M-extension op select.
- srca  input  XLEN  operand rs1 (multiplicand/dividend).
- srcb  input  XLEN  operand rs2 (multiplier/divisor).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  operation result.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0; counter and datapath registers cleared.
- funct3 decode:
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: high bits, signed x signed.
  - 010 MULHSU: high bits, signed srca x unsigned srcb.
  - 011 MULHU: high bits, unsigned x unsigned.
  - 100 DIV: signed quotient, truncated toward zero.
  - 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder; sign follows the dividend.
  - 111 REMU: unsigned remainder.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: an edge with in_valid & in_ready (edge E0) registers funct3, srca and srcb. Later input changes are ignored.
- Signed ops: operands are converted to magnitudes at E0 and the sign is applied to the final result. The internal product is 2*XLEN bits wide.
- Normal path: IDLE->CALC at E0 with counter=0.
  - One iteration per CALC edge: counter increments.
  - At iteration XLEN (edge E_XLEN): result is registered and state goes to DONE.
  - out_valid therefore rises exactly XLEN cycles after E0.
- Fast path: evaluated at E0; the next edge E1 registers the result and moves to DONE, so out_valid rises 1 cycle after E0.
  - Divide by zero (srcb=0, funct3[2]=1): DIV/DIVU give all-ones; REM/REMU give srca.
  - Signed overflow (DIV/REM with srca=-2^(XLEN-1) and srcb=-1): DIV gives srca; REM gives 0.
  - Multiplies never take the fast path.
- DONE: result and out_valid are held stable until out_ready=1. On that edge state goes to IDLE and out_valid=0; result keeps its last value.
- No overlap: in_ready=0 in CALC and DONE. A new operation can be accepted at the earliest on the cycle after the output handshake.
- in_valid while busy: ignored. The requester must hold it until in_ready is seen.
- out_ready while not in DONE: ignored.
- Reset mid-operation: reset_n low forces IDLE immediately (asynchronously). out_valid=0, in_ready=1 and the partial result is discarded. Operation resumes on the first clk edge after deassertion.

Test Plan:
- MUL: srca=7, srcb=0xFFFFFFFD, funct3=000 -> result 0xFFFFFFEB; out_valid exactly 32 cycles after the accept edge.
- High multiplies with srca=srcb=0x80000000: MULH -> 0x40000000, MULHU -> 0x40000000. MULHSU with srca=0xFFFFFFFF, srcb=2 -> 0xFFFFFFFF.
- Divide:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU 0xFFFFFFF9 / 2 -> 1.
- Fast path:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - All four: out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0 throughout. Raising out_ready gives IDLE next cycle; back-to-back ops complete correctly.
- Reset: drop reset_n at CALC iteration 15 -> out_valid=0 and in_ready=1 immediately. A following MUL 3x4 returns 12 with normal latency.
